// File: rtl/exmem_pipe_stage.sv
// exmem_pipe_stage: execute-to-memory pipeline register with valid/ready
// handshaking, an optional skid entry, flush-to-bubble and saturating
// stall/flush event counters.
module exmem_pipe_stage #(
  parameter int PAYLOAD_W = 198,
  parameter int CTRL_W    = 6,
  parameter int SKID      = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [CTRL_W-1:0]    in_ctrl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam bit HAS_SKID = (SKID != 0);

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // Main entry (drives the outputs)
  logic                 m_valid_q,   m_valid_d;
  logic [PAYLOAD_W-1:0] m_payload_q, m_payload_d;
  logic [CTRL_W-1:0]    m_ctrl_q,    m_ctrl_d;
  // Skid entry (stays empty when SKID=0)
  logic                 s_valid_q,   s_valid_d;
  logic [PAYLOAD_W-1:0] s_payload_q, s_payload_d;
  logic [CTRL_W-1:0]    s_ctrl_q,    s_ctrl_d;
  // Event counters
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;

  logic in_xfer_s;
  logic m_free_s;

  // With a skid entry in_ready is a pure flop output; without it the stage
  // can refill in the same cycle the memory stage drains it.
  assign in_ready  = HAS_SKID ? ~s_valid_q : (~m_valid_q | out_ready);
  assign in_xfer_s = in_valid & in_ready;
  assign m_free_s  = ~m_valid_q | out_ready;

  assign out_valid   = m_valid_q;
  assign out_payload = m_payload_q;
  assign out_ctrl    = m_ctrl_q & {CTRL_W{m_valid_q}};
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

  // Next-state: flush kills everything, otherwise skid drains before new input.
  always_comb begin
    m_valid_d   = m_valid_q;
    m_payload_d = m_payload_q;
    m_ctrl_d    = m_ctrl_q;
    s_valid_d   = s_valid_q;
    s_payload_d = s_payload_q;
    s_ctrl_d    = s_ctrl_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (flush) begin
      m_valid_d   = 1'b0;
      m_payload_d = {PAYLOAD_W{1'b0}};
      m_ctrl_d    = {CTRL_W{1'b0}};
      s_valid_d   = 1'b0;
      s_payload_d = {PAYLOAD_W{1'b0}};
      s_ctrl_d    = {CTRL_W{1'b0}};
      // Only count flushes that actually discarded an instruction.
      if (m_valid_q | s_valid_q | in_xfer_s) begin
        flush_cnt_d = sat_inc(flush_cnt_q);
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end else begin
      if (m_free_s) begin
        if (s_valid_q) begin
          m_valid_d   = 1'b1;
          m_payload_d = s_payload_q;
          m_ctrl_d    = s_ctrl_q;
          s_valid_d   = 1'b0;
        end else if (in_xfer_s) begin
          m_valid_d   = 1'b1;
          m_payload_d = in_payload;
          m_ctrl_d    = in_ctrl;
        end else begin
          // Bubble: payload is left as-is, ctrl is masked at the output.
          m_valid_d = 1'b0;
        end
      end else begin
        // Main is stalled; an accepted instruction parks in the skid entry.
        if (HAS_SKID && in_xfer_s) begin
          s_valid_d   = 1'b1;
          s_payload_d = in_payload;
          s_ctrl_d    = in_ctrl;
        end else begin
          s_valid_d = s_valid_q;
        end
      end

      if (m_valid_q & ~out_ready) begin
        stall_cnt_d = sat_inc(stall_cnt_q);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end
  end

  // State registers with synchronous reset that overrides flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q   <= 1'b0;
      m_payload_q <= {PAYLOAD_W{1'b0}};
      m_ctrl_q    <= {CTRL_W{1'b0}};
      s_valid_q   <= 1'b0;
      s_payload_q <= {PAYLOAD_W{1'b0}};
      s_ctrl_q    <= {CTRL_W{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      m_valid_q   <= m_valid_d;
      m_payload_q <= m_payload_d;
      m_ctrl_q    <= m_ctrl_d;
      s_valid_q   <= s_valid_d;
      s_payload_q <= s_payload_d;
      s_ctrl_q    <= s_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_exmem_pipe_stage.sv
// Directed bench for exmem_pipe_stage: three instances (SKID=1/CNT_W=16,
// SKID=1/CNT_W=4, SKID=0/CNT_W=16) share one stimulus stream.
module tb_exmem_pipe_stage;

  localparam int PW = 198;
  localparam int CW = 6;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [PW-1:0] in_payload;
  logic [CW-1:0] in_ctrl;
  logic          out_ready;

  logic          d1_in_ready, d1_out_valid;
  logic [PW-1:0] d1_out_payload;
  logic [CW-1:0] d1_out_ctrl;
  logic [15:0]   d1_stall_cnt, d1_flush_cnt;

  logic          d4_in_ready, d4_out_valid;
  logic [PW-1:0] d4_out_payload;
  logic [CW-1:0] d4_out_ctrl;
  logic [3:0]    d4_stall_cnt, d4_flush_cnt;

  logic          d0_in_ready, d0_out_valid;
  logic [PW-1:0] d0_out_payload;
  logic [CW-1:0] d0_out_ctrl;
  logic [15:0]   d0_stall_cnt, d0_flush_cnt;

  int vectors = 0;
  int errs    = 0;

  localparam logic [CW-1:0] CTRL_RW = 6'b000010;  // regwrite
  localparam logic [CW-1:0] CTRL_MW = 6'b000100;  // memwrite

  exmem_pipe_stage #(.PAYLOAD_W(PW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_d1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(d1_in_ready), .in_payload(in_payload), .in_ctrl(in_ctrl),
    .out_valid(d1_out_valid), .out_ready(out_ready), .out_payload(d1_out_payload),
    .out_ctrl(d1_out_ctrl), .stall_cnt(d1_stall_cnt), .flush_cnt(d1_flush_cnt));

  exmem_pipe_stage #(.PAYLOAD_W(PW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_d4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(d4_in_ready), .in_payload(in_payload), .in_ctrl(in_ctrl),
    .out_valid(d4_out_valid), .out_ready(out_ready), .out_payload(d4_out_payload),
    .out_ctrl(d4_out_ctrl), .stall_cnt(d4_stall_cnt), .flush_cnt(d4_flush_cnt));

  exmem_pipe_stage #(.PAYLOAD_W(PW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_d0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(d0_in_ready), .in_payload(in_payload), .in_ctrl(in_ctrl),
    .out_valid(d0_out_valid), .out_ready(out_ready), .out_payload(d0_out_payload),
    .out_ctrl(d0_out_ctrl), .stall_cnt(d0_stall_cnt), .flush_cnt(d0_flush_cnt));

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs {adder, alu, zero, writedata, rd} with rd-dependent field values.
  function automatic logic [PW-1:0] mk(input logic [4:0] rd);
    logic [63:0] adder, alu, wd;
    adder = 64'h0000_0000_0000_1000 + {59'd0, rd};
    alu   = 64'hA5A5_0000_0000_0000 | {59'd0, rd};
    wd    = 64'h0000_0000_DEAD_0000 | {59'd0, rd};
    return {adder, alu, 1'b1, wd, rd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  int unsigned exp_rd;
  int unsigned nxt_rd;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_payload = '0; in_ctrl = '0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", d1_out_valid, 1'b0);
    chk("rst_payload",   d1_out_payload, '0);
    chk("rst_ctrl",      d1_out_ctrl, '0);
    chk("rst_stall",     d1_stall_cnt, '0);
    chk("rst_flush",     d1_flush_cnt, '0);
    chk("rst_in_ready",  d1_in_ready, 1'b1);
    chk("rst_in_ready0", d0_in_ready, 1'b1);

    // Streaming rd=1..4 with out_ready=1: one per cycle, 1-cycle latency.
    in_ctrl = CTRL_RW;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_payload = mk(5'(i));
      tick();
      chk("stream_valid", d1_out_valid, 1'b1);
      chk("stream_rd",    d1_out_payload[4:0], 5'(i));
      chk("stream_ctrl",  d1_out_ctrl, CTRL_RW);
    end
    chk("stream_full_payload", d1_out_payload, mk(5'd4));
    in_valid = 1'b0;
    tick();
    chk("stream_drained", d1_out_valid, 1'b0);
    chk("stream_bubble_ctrl", d1_out_ctrl, '0);
    chk("stream_stall_cnt", d1_stall_cnt, '0);

    // Skid: stall while offering 5,6,7.
    out_ready = 1'b0; in_valid = 1'b1; in_payload = mk(5'd5);
    tick();
    chk("skid_m5", d1_out_payload[4:0], 5'd5);
    chk("skid_rdy1", d1_in_ready, 1'b1);
    in_payload = mk(5'd6);
    tick();
    chk("skid_rdy_low", d1_in_ready, 1'b0);
    chk("skid_m5_held", d1_out_payload[4:0], 5'd5);
    chk("skid_stall1", d1_stall_cnt, 16'd1);
    in_payload = mk(5'd7);
    tick();
    chk("skid_rdy_low2", d1_in_ready, 1'b0);
    tick();
    chk("skid_stall3", d1_stall_cnt, 16'd3);
    chk("skid_m5_still", d1_out_payload[4:0], 5'd5);
    out_ready = 1'b1;
    tick();
    chk("skid_drain_m6", d1_out_payload[4:0], 5'd6);
    chk("skid_rdy_rise", d1_in_ready, 1'b1);
    tick();
    chk("skid_m7", d1_out_payload[4:0], 5'd7);
    chk("skid_m7_valid", d1_out_valid, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("skid_empty", d1_out_valid, 1'b0);
    chk("skid_stall_final", d1_stall_cnt, 16'd3);

    // Flush with main and skid full and a memwrite offered upstream.
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = CTRL_MW; in_payload = mk(5'd8);
    tick();
    in_payload = mk(5'd9);
    tick();
    chk("fl_full_rdy", d1_in_ready, 1'b0);
    in_payload = mk(5'd10); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", d1_out_valid, 1'b0);
    chk("fl_ctrl", d1_out_ctrl, '0);
    chk("fl_payload", d1_out_payload, '0);
    chk("fl_cnt", d1_flush_cnt, 16'd1);
    chk("fl_rdy", d1_in_ready, 1'b1);
    chk("fl_stall_hold", d1_stall_cnt, 16'd4);
    tick();
    chk("fl_no_memwrite", d1_out_ctrl, '0);
    chk("fl_still_empty", d1_out_valid, 1'b0);

    // Flush on empty stage, then flush that drops an accepted input.
    out_ready = 1'b1; flush = 1'b1;
    tick();
    chk("fl_empty_cnt", d1_flush_cnt, 16'd1);
    in_valid = 1'b1; in_payload = mk(5'd10);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_drop_cnt", d1_flush_cnt, 16'd2);
    chk("fl_drop_valid", d1_out_valid, 1'b0);

    // Reset together with flush, mid-stall with skid full.
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = CTRL_RW; in_payload = mk(5'd11);
    tick();
    in_payload = mk(5'd12);
    tick();
    chk("rs_pre_stall", d1_stall_cnt, 16'd5);
    reset = 1'b1; flush = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("rs_valid", d1_out_valid, 1'b0);
    chk("rs_stall", d1_stall_cnt, '0);
    chk("rs_flush", d1_flush_cnt, '0);
    chk("rs_rdy", d1_in_ready, 1'b1);
    chk("rs_ctrl", d1_out_ctrl, '0);

    // Saturation with CNT_W=4: 20 stall cycles.
    in_valid = 1'b1; in_payload = mk(5'd13);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat4_cnt", d4_stall_cnt, 4'hF);
    chk("sat16_cnt", d1_stall_cnt, 16'd20);
    tick();
    chk("sat4_hold", d4_stall_cnt, 4'hF);
    chk("sat4_rd", d4_out_payload[4:0], 5'd13);

    // SKID=0: toggle out_ready, in_ready must follow in the same cycle.
    reset = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("s0_rst_rdy", d0_in_ready, 1'b1);
    chk("s0_rst_valid", d0_out_valid, 1'b0);
    in_valid = 1'b1; in_payload = mk(5'd20);
    tick();
    exp_rd = 20; nxt_rd = 21;
    for (int j = 0; j < 6; j++) begin
      out_ready = (j % 2 == 1);
      in_payload = mk(5'(nxt_rd));
      #1;
      chk("s0_rdy_follow", d0_in_ready, out_ready);
      chk("s0_valid", d0_out_valid, 1'b1);
      chk("s0_rd", d0_out_payload[4:0], 5'(exp_rd));
      tick();
      if (out_ready) begin
        exp_rd = nxt_rd;
        nxt_rd = nxt_rd + 1;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("s0_last_rd", d0_out_payload[4:0], 5'd23);
    tick();
    chk("s0_drained", d0_out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/exmem_pipe_stage.md
# exmem_pipe_stage

Parametrised execute-to-memory pipeline stage register for the RISC-V core with valid/ready flow control, an optional skid entry, flush-to-bubble, and saturating stall/flush counters. It sits between the execute and memory stages. It carries a generic payload: adder output, ALU result, zero flag, store data and rd. Control bits are forced to zero whenever the stage holds a bubble. It lets the memory stage stall the pipeline without losing an instruction.

## Interface

Parameters:
- PAYLOAD_W, 198: payload width, packed {adder 64, alu 64, zero 1, writedata 64, rd 5}.
- CTRL_W, 6: control width, packed {branch, memread, memtoreg, memwrite, regwrite, addermuxselect}.
- SKID, 1: 1 adds a second entry so in_ready is registered; 0 gives a single entry with combinational in_ready.
- CNT_W, 16: counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous kill of all held and incoming instructions.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_payload  in  PAYLOAD_W  data fields.
- in_ctrl  in  CTRL_W  control fields.
- out_valid  out  1  memory stage input is valid.
- out_ready  in  1  memory stage consumes this cycle.
- out_payload  out  PAYLOAD_W  data fields.
- out_ctrl  out  CTRL_W  control fields, zero when out_valid=0.
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready.
- flush_cnt  out  CNT_W  flush cycles that killed at least one instruction.

## Operation

- Storage: main entry {m_valid, m_payload, m_ctrl}, driving the outputs. When SKID=1 there is also a skid entry {s_valid, s_payload, s_ctrl}.
- Input transfer: `in_valid & in_ready`. Output transfer: `out_valid & out_ready`.
- in_ready:
  - SKID=1: `!s_valid`.
  - SKID=0: `!m_valid | out_ready`.
- Main entry update, when `!m_valid | out_ready`:
  - Load from skid if s_valid, then clear s_valid.
  - Otherwise load from input on an input transfer.
  - Otherwise set m_valid=0.
- Skid load, SKID=1 only: on an input transfer while `m_valid & !out_ready`, capture the input into skid and set s_valid=1.
  - s_valid=1 and an input transfer cannot coincide, because in_ready=0.
- Order is preserved: skid contents always leave before newer input.
- out_ctrl = m_ctrl & {CTRL_W{m_valid}}. out_payload = m_payload, held unchanged while a bubble.
- Flush, priority over normal update, below reset:
  - m_valid and s_valid are cleared. m_ctrl and s_ctrl are zeroed. Payload registers are zeroed.
  - An input transfer in the same cycle is consumed and dropped, because in_ready follows the normal rule.
  - flush_cnt increments if any of m_valid, s_valid or the input transfer was true.
- Reset: all valids, payloads, ctrls and counters go to 0. Reset beats flush.
- Counters are saturating: they hold at all-ones and never wrap.
  - stall_cnt increments on `m_valid & !out_ready`, but not in a flush or reset cycle.

## Timing

- Latency: 1 cycle from input transfer to out_valid when the stage is empty.
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- Reset values: out_valid=0, out_payload=0, out_ctrl=0, stall_cnt=0, flush_cnt=0.
  - in_ready=1 after reset for SKID=1. For SKID=0 it is 1 because m_valid=0.
- in_ready is combinational from out_ready only when SKID=0. When SKID=1 it is a pure flop output.
- Stall release, SKID=1: the first cycle with out_ready=1 drains the skid into main, and in_ready rises the next cycle.
- Boundary conditions:
  - Flush during stall: the next cycle shows out_valid=0 and in_ready=1.
  - Flush and reset together: reset behaviour applies and flush_cnt does not increment.
  - Reset asserted mid-stall: all held instructions are lost and no counter increments.
  - Counter at all-ones with another qualifying event: value unchanged.

## Test plan

- After reset, stream 4 instructions with rd=1..4 and out_ready=1. Require out_valid from cycle 1, rd=1,2,3,4 on consecutive cycles, and stall_cnt=0.
- SKID=1: hold out_ready=0 for 3 cycles while offering rd=5,6,7. Require rd=5 in main, rd=6 in skid, in_ready=0 from the 2nd stall cycle, and rd=7 held upstream. Release out_ready and require output order 5,6,7 with no loss. Require stall_cnt=3.
- Flush while main and skid are full and in_valid=1 with memwrite=1. Require out_valid=0 and out_ctrl=0 next cycle, no memwrite pulse, flush_cnt=1, and in_ready=1.
- Flush with the stage empty and in_valid=0. Require flush_cnt unchanged.
- CNT_W=4, stall for 20 cycles. Require stall_cnt=15 held, with no wrap to 0.
- SKID=0: with out_valid=1, toggle out_ready each cycle. Require in_ready to equal out_ready in the same cycle, and the stream to be delivered in order without duplication.
